// File: rtl/data_access_unit_pkg.sv
// Shared definitions for the data access unit and the load/store buffer:
// access-type codes, FSM state encoding, byte-count and IO-address helpers.
package data_access_unit_pkg;

   localparam logic [1:0] ACC_NONE = 2'b00;
   localparam logic [1:0] ACC_BYTE = 2'b01;
   localparam logic [1:0] ACC_HALF = 2'b10;
   localparam logic [1:0] ACC_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_t;

   // Number of bytes moved by an access type.
   function automatic logic [2:0] acc_bytes(input logic [1:0] t);
      case (t)
         ACC_BYTE: return 3'd1;
         ACC_HALF: return 3'd2;
         ACC_WORD: return 3'd4;
         default:  return 3'd0;
      endcase
   endfunction

   // IO region: both selector bits set.
   function automatic logic is_io_addr(input logic [31:0] addr,
                                       input logic [4:0]  hi,
                                       input logic [4:0]  lo);
      return addr[hi] & addr[lo];
   endfunction

endpackage

// File: rtl/load_data_extender.sv
// Combinational read-data extender: byte/half results are sign- or
// zero-extended to 32 bits. Ports: i_buf, i_type, i_signed -> o_data.
module load_data_extender
   import data_access_unit_pkg::*;
(
   input  logic [31:0] i_buf,
   input  logic [1:0]  i_type,
   input  logic        i_signed,
   output logic [31:0] o_data
);

   always_comb begin
      o_data = i_buf;
      case (i_type)
         ACC_BYTE: o_data = {{24{i_signed & i_buf[7]}}, i_buf[7:0]};
         ACC_HALF: o_data = {{16{i_signed & i_buf[15]}}, i_buf[15:0]};
         default:  o_data = i_buf;
      endcase
   end

endmodule

// File: rtl/data_access_unit.sv
// Serialises load/store-buffer requests into little-endian byte accesses
// on the 8-bit memory port. Request in: accessType/readWriteIn/signedIn/
// dataAddr/dataIn; results: dataValid/dataOut, dataWriteSuc, busy;
// memory: memIn/memOut/memAddr/memWrite, IO back-pressure ioBufferFull.
module data_access_unit
   import data_access_unit_pkg::*;
#(
   parameter int IO_SEL_HI = 17,
   parameter int IO_SEL_LO = 16
) (
   input  logic        clockIn,
   input  logic        resetIn,
   input  logic        clearIn,
   input  logic [1:0]  accessType,
   input  logic        readWriteIn,
   input  logic        signedIn,
   input  logic [31:0] dataAddr,
   input  logic [31:0] dataIn,
   output logic        dataValid,
   output logic [31:0] dataOut,
   output logic        dataWriteSuc,
   output logic        busy,
   input  logic [7:0]  memIn,
   output logic [7:0]  memOut,
   output logic [31:0] memAddr,
   output logic        memWrite,
   input  logic        ioBufferFull
);

   localparam logic [4:0] SEL_HI = IO_SEL_HI[4:0];
   localparam logic [4:0] SEL_LO = IO_SEL_LO[4:0];

   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_type;
   logic        r_signed;
   logic [2:0]  r_n;
   // READ: edges seen since acceptance. WRITE: bytes put on the port.
   logic [2:0]  r_cnt;
   logic [31:0] r_buf;
   logic [31:0] r_data_out;
   logic        r_valid;
   logic        r_wsuc;
   logic        r_busy;
   logic [7:0]  r_mem_out;
   logic [31:0] r_mem_addr;
   logic        r_mem_wr;

   logic        w_accept;
   logic [31:0] w_byte_addr;
   logic [31:0] w_next_addr;
   logic [7:0]  w_wr_byte;
   logic        w_stall;
   logic        w_stall_new;
   logic [1:0]  w_cap_idx;
   logic [31:0] w_buf_next;
   logic [31:0] w_ext;

   assign w_accept = (r_state == ST_IDLE || r_state == ST_DONE)
                   && accessType != ACC_NONE && !clearIn;

   assign w_byte_addr = r_addr + {29'd0, r_cnt};
   assign w_next_addr = r_addr + {29'd0, r_cnt + 3'd1};
   assign w_wr_byte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
   assign w_stall     = ioBufferFull
                      & is_io_addr(w_byte_addr, SEL_HI, SEL_LO);
   assign w_stall_new = ioBufferFull
                      & is_io_addr(dataAddr, SEL_HI, SEL_LO);

   // memIn carries the byte addressed one cycle earlier.
   assign w_cap_idx = r_cnt[1:0] - 2'd1;

   always_comb begin
      w_buf_next = r_buf;
      w_buf_next[{w_cap_idx, 3'b000} +: 8] = memIn;
   end

   load_data_extender u_ext (
      .i_buf    (w_buf_next),
      .i_type   (r_type),
      .i_signed (r_signed),
      .o_data   (w_ext)
   );

   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_type     <= ACC_NONE;
         r_signed   <= 1'b0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_buf      <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_wsuc     <= 1'b0;
         r_busy     <= 1'b0;
         r_mem_out  <= '0;
         r_mem_addr <= '0;
         r_mem_wr   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_wsuc  <= 1'b0;
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               r_mem_wr <= 1'b0;
               if (w_accept) begin
                  r_addr     <= dataAddr;
                  r_wdata    <= dataIn;
                  r_type     <= accessType;
                  r_signed   <= signedIn;
                  r_n        <= acc_bytes(accessType);
                  r_busy     <= 1'b1;
                  r_mem_addr <= dataAddr;
                  if (readWriteIn) begin
                     r_state <= ST_READ;
                     r_cnt   <= 3'd0;
                  end else begin
                     r_state   <= ST_WRITE;
                     r_mem_out <= dataIn[7:0];
                     r_mem_wr  <= !w_stall_new;
                     r_cnt     <= w_stall_new ? 3'd0 : 3'd1;
                  end
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_READ: begin
               if (clearIn) begin
                  r_state    <= ST_IDLE;
                  r_busy     <= 1'b0;
                  r_mem_addr <= '0;
               end else begin
                  if (r_cnt != 3'd0) r_buf <= w_buf_next;
                  if (r_cnt == r_n) begin
                     r_data_out <= w_ext;
                     r_valid    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= ST_DONE;
                  end else if (r_cnt + 3'd1 < r_n) begin
                     r_mem_addr <= w_next_addr;
                  end
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_WRITE: begin
               // Stores run to completion; clearIn is not looked at here.
               if (r_cnt == r_n) begin
                  r_mem_wr <= 1'b0;
                  r_wsuc   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_DONE;
               end else begin
                  r_mem_addr <= w_byte_addr;
                  r_mem_out  <= w_wr_byte;
                  r_mem_wr   <= !w_stall;
                  if (!w_stall) r_cnt <= r_cnt + 3'd1;
               end
            end
         endcase
      end
   end

   assign dataValid    = r_valid;
   assign dataOut      = r_data_out;
   assign dataWriteSuc = r_wsuc;
   assign busy         = r_busy;
   assign memOut       = r_mem_out;
   assign memAddr      = r_mem_addr;
   assign memWrite     = r_mem_wr;

endmodule
